// File: rtl/tnn_feature_packer_if.sv
// Handshake bundle between the raw feature feeder (master) and the TNN feature packer (slave).
interface tnn_feature_packer_if #(
    parameter int unsigned IN_W = 8,
    parameter int unsigned Q_W  = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [Q_W-1:0]  out_a;
    logic [Q_W-1:0]  out_b;
    logic [Q_W-1:0]  out_c;
    logic [Q_W-1:0]  out_d;
    logic            err_frame;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_c, out_d, err_frame
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_a, out_b, out_c, out_d, err_frame
    );
endinterface

// File: rtl/tnn_feature_packer.sv
// Quantises raw features and packs four per frame (a,b,c,d) for the TNN comparator neuron.
// Optional TNN_PACKER_SKID_EN adds a second frame buffer so collection overlaps presentation.
module tnn_feature_packer #(
    parameter int unsigned IN_W = 8,
    parameter int unsigned Q_W  = 3
) (
    input logic                 clk,
    input logic                 rst,
    tnn_feature_packer_if.slave io_bus
);
    localparam int unsigned SH = IN_W - Q_W;
    localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SH - 1);
    localparam logic [IN_W:0] QMAX_W = {{(SH + 1){1'b0}}, {Q_W{1'b1}}};

    // Round half up; the extra bit keeps x = 2**IN_W-1 from wrapping before saturation.
    function automatic logic [Q_W-1:0] quantise(input logic [IN_W-1:0] x);
        logic [IN_W:0] sum;
        logic [IN_W:0] scaled;
        sum    = {1'b0, x} + HALF;
        scaled = sum >> SH;
        return (scaled > QMAX_W) ? {Q_W{1'b1}} : scaled[Q_W-1:0];
    endfunction

    logic [Q_W-1:0]       w_q;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_close;
    logic                 w_frame_err;
    logic [3:0][Q_W-1:0]  w_frame;
    logic [3:0][Q_W-1:0]  r_acc;
    logic [3:0][Q_W-1:0]  r_out;
    logic [1:0]           r_idx;
    logic                 r_err;

    assign w_q         = quantise(io_bus.in_data);
    assign w_accept    = io_bus.in_valid & w_in_ready;
    assign w_close     = w_accept & ((r_idx == 2'd3) | io_bus.in_last);
    // Short frame (last before lane d) or long frame (lane d without last).
    assign w_frame_err = io_bus.in_last ^ (r_idx == 2'd3);

    always_comb begin
        w_frame        = r_acc;
        w_frame[r_idx] = w_q;
    end

    // The accumulator is cleared on close, so unwritten lanes of the next frame read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_idx <= 2'd0;
        end else if (w_accept) begin
            if (w_close) begin
                r_acc <= '0;
                r_idx <= 2'd0;
            end else begin
                r_acc[r_idx] <= w_q;
                r_idx        <= r_idx + 2'd1;
            end
        end
    end

`ifdef TNN_PACKER_SKID_EN
    logic [3:0][Q_W-1:0] r_hold;
    logic                r_hold_valid;
    logic                r_hold_err;
    logic                r_out_valid;
    logic                w_pop;

    assign w_in_ready  = ~r_hold_valid;
    assign w_out_valid = r_out_valid;
    assign w_pop       = r_out_valid & io_bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_hold_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_pop) begin
                // A close cannot coincide with a full hold buffer: in_ready is low then.
                if (r_hold_valid) begin
                    r_out        <= r_hold;
                    r_err        <= r_hold_err;
                    r_hold_valid <= 1'b0;
                end else if (w_close) begin
                    r_out <= w_frame;
                    r_err <= w_frame_err;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_close) begin
                if (!r_out_valid) begin
                    r_out       <= w_frame;
                    r_out_valid <= 1'b1;
                    r_err       <= w_frame_err;
                end else begin
                    r_hold       <= w_frame;
                    r_hold_valid <= 1'b1;
                    r_hold_err   <= w_frame_err;
                end
            end
        end
    end
`else
    typedef enum logic {StCollect, StPresent} state_e;

    state_e r_state;
    state_e w_state_d;

    assign w_out_valid = (r_state == StPresent);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StCollect;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            StCollect: begin
                w_in_ready = 1'b1;
                if (w_close) begin
                    w_state_d = StPresent;
                end
            end
            StPresent: begin
                if (io_bus.out_ready) begin
                    w_state_d = StCollect;
                end
            end
            default: begin
                w_state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_close) begin
                r_out <= w_frame;
                r_err <= w_frame_err;
            end
        end
    end
`endif

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.out_a     = r_out[0];
    assign io_bus.out_b     = r_out[1];
    assign io_bus.out_c     = r_out[2];
    assign io_bus.out_d     = r_out[3];
    assign io_bus.err_frame = r_err;
endmodule

// File: tb/tb_tnn_feature_packer.sv
// Self-checking bench for tnn_feature_packer: directed frames plus a long random run against
// a frame-level reference model (expected-frame queue and partial feature list).
module tb_tnn_feature_packer;
    localparam int unsigned IN_W = 8;
    localparam int unsigned Q_W  = 3;
    localparam int SH   = IN_W - Q_W;
    localparam int QMAX = (1 << Q_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tnn_feature_packer_if #(.IN_W(IN_W), .Q_W(Q_W)) bus ();

    tnn_feature_packer #(.IN_W(IN_W), .Q_W(Q_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int err;
    } frame_t;

    frame_t exp_q[$];
    frame_t got_q[$];
    int     part[4];
    int     part_n;
    bit     fresh;
    bit     prev_free;
    int     n_closed;
    int     n_popped;
    int     checks = 0;
    int     errors = 0;

    frame_t mon_f;
    frame_t mon_g;
    int     mon_sz;
    bit     mon_popped;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual timeout required completion at %0t", name, $time);
    endtask

    function automatic int qref(input int x);
        int q;
        q = (x + (1 << (SH - 1))) / (1 << SH);
        return (q > QMAX) ? QMAX : q;
    endfunction

    // Reference model: compare against the model first, then apply this cycle's handshakes.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            part_n    = 0;
            fresh     = 1'b0;
            prev_free = 1'b1;
            n_closed  = 0;
            n_popped  = 0;
        end else begin
            mon_sz = exp_q.size();
`ifdef TNN_PACKER_SKID_EN
            chk("in_ready", int'(bus.in_ready), int'(mon_sz < 2));
`else
            chk("in_ready", int'(bus.in_ready), int'(mon_sz == 0));
`endif
            chk("out_valid", int'(bus.out_valid), int'(mon_sz > 0));
            if (bus.out_valid && mon_sz > 0) begin
                chk("out_a", int'(bus.out_a), exp_q[0].a);
                chk("out_b", int'(bus.out_b), exp_q[0].b);
                chk("out_c", int'(bus.out_c), exp_q[0].c);
                chk("out_d", int'(bus.out_d), exp_q[0].d);
                chk("err_frame", int'(bus.err_frame), (exp_q[0].err != 0 && fresh) ? 1 : 0);
            end else begin
                chk("err_idle", int'(bus.err_frame), 0);
            end
            if (bus.out_valid && prev_free) begin
                mon_g.a   = int'(bus.out_a);
                mon_g.b   = int'(bus.out_b);
                mon_g.c   = int'(bus.out_c);
                mon_g.d   = int'(bus.out_d);
                mon_g.err = int'(bus.err_frame);
                got_q.push_back(mon_g);
            end
            prev_free  = !bus.out_valid || bus.out_ready;
            mon_popped = 1'b0;
            if (bus.out_valid && bus.out_ready && mon_sz > 0) begin
                void'(exp_q.pop_front());
                n_popped++;
                mon_popped = 1'b1;
            end
            fresh = mon_popped && exp_q.size() > 0;
            if (bus.in_valid && bus.in_ready) begin
                part[part_n] = qref(int'(bus.in_data));
                part_n++;
                if (part_n == 4 || bus.in_last) begin
                    mon_f.a   = part[0];
                    mon_f.b   = (part_n > 1) ? part[1] : 0;
                    mon_f.c   = (part_n > 2) ? part[2] : 0;
                    mon_f.d   = (part_n > 3) ? part[3] : 0;
                    mon_f.err = (part_n == 4 && bus.in_last) ? 0 : 1;
                    if (exp_q.size() == 0) fresh = 1'b1;
                    exp_q.push_back(mon_f);
                    n_closed++;
                    part_n = 0;
                end
            end
        end
    end

    task automatic send(input int x, input bit last);
        int n;
        n            = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = IN_W'(x);
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) fail_now("send_accept");
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n             = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || bus.out_valid) && n < 50);
        if (exp_q.size() != 0 || bus.out_valid) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string name, input int idx, input int a, input int b,
                             input int c, input int d, input int err);
        if (got_q.size() <= idx) begin
            checks++;
            errors++;
            $display("FAIL %s actual %0d frames required frame %0d", name, got_q.size(), idx);
        end else begin
            chk({name, "_a"}, got_q[idx].a, a);
            chk({name, "_b"}, got_q[idx].b, b);
            chk({name, "_c"}, got_q[idx].c, c);
            chk({name, "_d"}, got_q[idx].d, d);
            chk({name, "_err"}, got_q[idx].err, err);
        end
    endtask

    initial begin
        int sent;
        int cyc;
        bit acc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_err", int'(bus.err_frame), 0);
        chk("rst_lanes", int'({bus.out_a, bus.out_b, bus.out_c, bus.out_d}), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: rounding and saturation, well-formed frame
        got_q.delete();
        bus.out_ready = 1'b1;
        send(0, 0); send(31, 0); send(32, 0); send(255, 1);
        drain();
        chk_frame("t1", 0, 0, 1, 1, 7, 0);
        chk("t1_count", got_q.size(), 1);

        // T2: short frame zero-padded
        got_q.delete();
        send(100, 0); send(200, 1);
        drain();
        chk_frame("t2", 0, 3, 6, 0, 0, 1);

        // T3: long frame, fifth feature starts the next frame
        got_q.delete();
        send(10, 0); send(40, 0); send(70, 0); send(130, 0); send(250, 0);
        send(60, 1);
        drain();
        chk_frame("t3f1", 0, 0, 1, 2, 4, 1);
        chk_frame("t3f2", 1, 7, 2, 0, 0, 1);

        // T4: backpressure holds the frame stable
        got_q.delete();
        bus.out_ready = 1'b0;
        send(64, 0); send(96, 0); send(160, 0); send(192, 1);
`ifdef TNN_PACKER_SKID_EN
        send(16, 0); send(48, 0); send(80, 0); send(112, 1);
`endif
        bus.in_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("t4_in_ready", int'(bus.in_ready), 0);
            chk("t4_out_valid", int'(bus.out_valid), 1);
            chk("t4_out_a", int'(bus.out_a), 2);
        end
        @(posedge clk);
        #1;
        drain();
        chk_frame("t4f1", 0, 2, 3, 5, 6, 0);
`ifdef TNN_PACKER_SKID_EN
        chk_frame("t4f2", 1, 1, 2, 3, 4, 0);
`endif

        // T5: asynchronous reset while a frame is presented
        bus.out_ready = 1'b0;
        send(255, 0); send(255, 0); send(255, 0); send(255, 1);
`ifdef TNN_PACKER_SKID_EN
        send(128, 0); send(128, 0);
`endif
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_out_valid", int'(bus.out_valid), 0);
        chk("t5_lanes", int'({bus.out_a, bus.out_b, bus.out_c, bus.out_d}), 0);
        chk("t5_err", int'(bus.err_frame), 0);
        chk("t5_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        bus.out_ready = 1'b1;
        send(200, 0); send(100, 0); send(50, 0); send(0, 1);
        drain();
        chk_frame("t5", 0, 6, 3, 2, 0, 0);
        chk("t5_count", got_q.size(), 1);

        // T6: random traffic against the model
        sent = 0;
        cyc  = 0;
        bus.in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) sent++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = IN_W'($urandom);
                bus.in_last  = ($urandom_range(0, 4) == 0);
            end
        end
        chk("t6_sent", sent, 10000);
        send(0, 1);
        drain();
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_frames", n_popped, n_closed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
